// File: rtl/phy_rx_demux_lanes.sv
`default_nettype none
// ============================================================================
// Module   : phy_rx_demux_lanes
// Purpose  : 1-to-LANES round-robin word demux, valid/ready on both sides.
//            Define DEMUX_FLUSH_EN to flush partial groups after an idle gap.
// Revision : 1.0 - initial release
// ============================================================================
module phy_rx_demux_lanes #(
    parameter int WIDTH       = 8,
    parameter int LANES       = 4,
    parameter int IDLE_CYCLES = 4
) (
    input  logic                       clk_4f,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       valid_in,
    output logic                       ready_in,
    output logic [LANES*WIDTH-1:0]     data_out,
    output logic                       valid_out,
    input  logic                       ready_out,
    output logic [LANES-1:0]           lane_valid,
    output logic [$clog2(LANES)-1:0]   lane_ptr
);

    localparam int                 c_PTR_W = $clog2(LANES);
    localparam int                 c_ASM_W = (LANES - 1) * WIDTH;
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(LANES - 1);

    // The last lane never lands in the assembly; it goes straight to data_out.
    logic [c_ASM_W-1:0]      r_asm;
    logic [c_PTR_W-1:0]      r_ptr;
    logic [LANES*WIDTH-1:0]  r_data;
    logic                    r_valid;
    logic [LANES-1:0]        r_lane_valid;

    logic                    w_last;
    logic                    w_slot_free;
    logic                    w_xfer;
    logic                    w_load;
    logic                    w_flush;
    logic [LANES-1:0]        w_flush_mask;

    assign w_last      = (r_ptr == c_LAST);
    assign w_slot_free = !r_valid || ready_out;
    assign ready_in    = !w_last || w_slot_free;
    assign w_xfer      = valid_in && ready_in;
    assign w_load      = w_xfer && w_last;

`ifdef DEMUX_FLUSH_EN
    logic [7:0]       r_idle;
    logic [LANES-1:0] r_fill;

    // Fires on the idle edge that brings the counter up to IDLE_CYCLES,
    // or later once the output slot frees up.
    assign w_flush      = !valid_in && (r_ptr != '0) && w_slot_free &&
                          (r_idle >= 8'(IDLE_CYCLES - 1));
    assign w_flush_mask = r_fill;

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            r_idle <= '0;
            r_fill <= '0;
        end else if (w_load || w_flush) begin
            r_idle <= '0;
            r_fill <= '0;
        end else if (w_xfer) begin
            r_idle        <= '0;
            r_fill[r_ptr] <= 1'b1;
        end else if (!valid_in && (r_ptr != '0) && (r_idle < 8'(IDLE_CYCLES))) begin
            r_idle <= r_idle + 8'd1;
        end
    end
`else
    assign w_flush      = 1'b0;
    assign w_flush_mask = '1;
`endif

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            r_asm        <= '0;
            r_ptr        <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_lane_valid <= '0;
        end else if (w_load) begin
            r_data       <= {data_in, r_asm};
            r_valid      <= 1'b1;
            r_lane_valid <= '1;
            r_ptr        <= '0;
            r_asm        <= '0;
        end else if (w_flush) begin
            // Unfilled slots are still zero because the assembly clears on every load.
            r_data       <= {{WIDTH{1'b0}}, r_asm};
            r_valid      <= 1'b1;
            r_lane_valid <= w_flush_mask;
            r_ptr        <= '0;
            r_asm        <= '0;
        end else begin
            if (w_xfer) begin
                for (int k = 0; k < LANES - 1; k++) begin
                    if (r_ptr == c_PTR_W'(k)) begin
                        r_asm[k*WIDTH +: WIDTH] <= data_in;
                    end
                end
                r_ptr <= r_ptr + c_PTR_W'(1);
            end
            if (r_valid && ready_out) begin
                r_valid      <= 1'b0;
                r_lane_valid <= '0;
            end
        end
    end

    assign data_out   = r_data;
    assign valid_out  = r_valid;
    assign lane_valid = r_lane_valid;
    assign lane_ptr   = r_ptr;

endmodule
`default_nettype wire

// File: tb/tb_phy_rx_demux_lanes.sv
`default_nettype none
// Bench for phy_rx_demux_lanes: vector table, scoreboard monitor and
// hand-written sequences on a 4-lane and a 2-lane instance.
module tb_phy_rx_demux_lanes;

    localparam int L = 4;

    logic        clk_4f = 1'b0;
    logic        reset;
    logic [7:0]  data_in;
    logic        valid_in;
    logic        ready_in;
    logic [31:0] data_out;
    logic        valid_out;
    logic        ready_out;
    logic [3:0]  lane_valid;
    logic [1:0]  lane_ptr;

    logic [7:0]  d2_data_in;
    logic        d2_valid_in;
    logic        d2_ready_in;
    logic [15:0] d2_data_out;
    logic        d2_valid_out;
    logic        d2_ready_out;
    logic [1:0]  d2_lane_valid;
    logic        d2_lane_ptr;

    always #5 clk_4f = ~clk_4f;

    phy_rx_demux_lanes #(.WIDTH(8), .LANES(4), .IDLE_CYCLES(4)) dut (
        .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_in(ready_in), .data_out(data_out), .valid_out(valid_out),
        .ready_out(ready_out), .lane_valid(lane_valid), .lane_ptr(lane_ptr)
    );

    phy_rx_demux_lanes #(.WIDTH(8), .LANES(2), .IDLE_CYCLES(4)) dut2 (
        .clk_4f(clk_4f), .reset(reset), .data_in(d2_data_in), .valid_in(d2_valid_in),
        .ready_in(d2_ready_in), .data_out(d2_data_out), .valid_out(d2_valid_out),
        .ready_out(d2_ready_out), .lane_valid(d2_lane_valid), .lane_ptr(d2_lane_ptr)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  lv;
    } grp_t;

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic       rdy;
        logic       e_rin;
        logic [1:0] e_ptr;
        logic       e_vo;
    } vec_t;

    grp_t       exp_q[$];
    logic [7:0] m_words[$];
    vec_t       vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_accept(input logic [7:0] w);
        grp_t g;
        m_words.push_back(w);
        if (m_words.size() == L) begin
            g.data = {m_words[3], m_words[2], m_words[1], m_words[0]};
            g.lv   = 4'hF;
            exp_q.push_back(g);
            m_words.delete();
        end
    endtask

    // Compare every drained group against the scoreboard.
    always @(negedge clk_4f) begin
        if (reset === 1'b0 && valid_out === 1'b1 && ready_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=%h expected=none", data_out);
            end else begin
                grp_t g;
                g = exp_q.pop_front();
                chk("sb_data", data_out, g.data);
                chk("sb_lane_valid", 32'(lane_valid), 32'(g.lv));
            end
        end
    end

    task automatic send(input logic [7:0] w);
        int n;
        n = 0;
        data_in  = w;
        valid_in = 1'b1;
        #1;
        while (ready_in !== 1'b1 && n < 50) begin
            @(posedge clk_4f);
            #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=ready_in_low expected=ready_in_high");
            valid_in = 1'b0;
        end else begin
            @(posedge clk_4f);
            model_accept(w);
            #1;
            chk("ptr_after_send", 32'(lane_ptr), 32'(m_words.size()));
        end
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) @(posedge clk_4f);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] w2[4];
        time        t0;

        vecs[0]  = '{8'hDD, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0};
        vecs[1]  = '{8'hEE, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0};
        vecs[2]  = '{8'hCC, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0};
        vecs[3]  = '{8'hBB, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1};
        vecs[4]  = '{8'h99, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1};
        vecs[5]  = '{8'hAA, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1};
        vecs[6]  = '{8'h88, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1};
        vecs[7]  = '{8'h77, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1};
        vecs[8]  = '{8'h77, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1};
        vecs[9]  = '{8'h77, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1};
        vecs[10] = '{8'h00, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0};
        vecs[11] = '{8'hDD, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0};
        vecs[12] = '{8'hEE, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0};
        vecs[13] = '{8'h5A, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0};
        vecs[14] = '{8'h5A, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0};
        vecs[15] = '{8'h5A, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0};
        vecs[16] = '{8'hCC, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0};
        vecs[17] = '{8'hBB, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1};
        vecs[18] = '{8'h00, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0};
        vecs[19] = '{8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0};

        reset        = 1'b1;
        data_in      = '0;
        valid_in     = 1'b0;
        ready_out    = 1'b0;
        d2_data_in   = '0;
        d2_valid_in  = 1'b0;
        d2_ready_out = 1'b1;
        repeat (2) @(posedge clk_4f);
        #1;
        chk("reset_ready_in",   32'(ready_in),   32'd1);
        chk("reset_valid_out",  32'(valid_out),  32'd0);
        chk("reset_lane_valid", 32'(lane_valid), 32'd0);
        chk("reset_lane_ptr",   32'(lane_ptr),   32'd0);
        chk("reset_data_out",   data_out,        32'd0);
        reset = 1'b0;

        // Stall, drain-with-load and valid gaps from the vector table.
        for (int i = 0; i < 20; i++) begin
            data_in   = vecs[i].d;
            valid_in  = vecs[i].v;
            ready_out = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d_ready_in", i), 32'(ready_in), 32'(vecs[i].e_rin));
            if (i == 8) chk("stall_data_hold", data_out, 32'hBBCCEEDD);
            @(posedge clk_4f);
            if (vecs[i].v && vecs[i].e_rin) model_accept(vecs[i].d);
            #1;
            chk($sformatf("vec%0d_lane_ptr", i),  32'(lane_ptr),  32'(vecs[i].e_ptr));
            chk($sformatf("vec%0d_valid_out", i), 32'(valid_out), 32'(vecs[i].e_vo));
        end

        // Back-to-back stream, one word per cycle.
        ready_out = 1'b1;
        idle(1);
        t0 = $time;
        send(8'hDD); send(8'hEE); send(8'hCC); send(8'hBB);
        chk("b2b_valid_out",  32'(valid_out),  32'd1);
        chk("b2b_data_out",   data_out,        32'hBBCCEEDD);
        chk("b2b_lane_valid", 32'(lane_valid), 32'hF);
        send(8'h99); send(8'hAA); send(8'h88); send(8'h77);
        chk("b2b_data_out2",  data_out,        32'h7788AA99);
        chk("b2b_cycles",     32'(($time - t0) / 10), 32'd8);
        idle(2);

        // Reset in the middle of a group.
        send(8'hDD); send(8'hEE);
        reset = 1'b1;
        #1;
        chk("midrst_valid_out",  32'(valid_out),  32'd0);
        chk("midrst_lane_valid", 32'(lane_valid), 32'd0);
        chk("midrst_lane_ptr",   32'(lane_ptr),   32'd0);
        chk("midrst_data_out",   data_out,        32'd0);
        chk("midrst_ready_in",   32'(ready_in),   32'd1);
        m_words.delete();
        exp_q.delete();
        valid_in = 1'b0;
        @(posedge clk_4f);
        #1;
        reset = 1'b0;
        send(8'hCC); send(8'hBB); send(8'h99); send(8'hAA);
        chk("postrst_data_out", data_out, 32'hAA99BBCC);
        idle(2);

        // Partial group followed by an idle gap.
        send(8'h11); send(8'h22);
`ifdef DEMUX_FLUSH_EN
        m_words.delete();
        exp_q.push_back('{32'h00002211, 4'b0011});
        idle(4);
        chk("flush_valid_out",  32'(valid_out),  32'd1);
        chk("flush_data_out",   data_out,        32'h00002211);
        chk("flush_lane_valid", 32'(lane_valid), 32'h3);
        chk("flush_lane_ptr",   32'(lane_ptr),   32'd0);
        idle(2);
`else
        idle(10);
        chk("partial_valid_out", 32'(valid_out), 32'd0);
        chk("partial_lane_ptr",  32'(lane_ptr),  32'd2);
        send(8'h33); send(8'h44);
        chk("partial_data_out",  data_out,       32'h44332211);
        idle(2);
`endif

        // Two-lane instance.
        w2[0] = 8'hFF; w2[1] = 8'hDD; w2[2] = 8'hEE; w2[3] = 8'hCC;
        for (int i = 0; i < 4; i++) begin
            d2_data_in  = w2[i];
            d2_valid_in = 1'b1;
            #1;
            chk($sformatf("l2_ready_in%0d", i), 32'(d2_ready_in), 32'd1);
            @(posedge clk_4f);
            #1;
            chk($sformatf("l2_lane_ptr%0d", i), 32'(d2_lane_ptr), 32'((i + 1) % 2));
            if (i == 1) chk("l2_group0", 32'(d2_data_out), 32'h0000DDFF);
            if (i == 3) chk("l2_group1", 32'(d2_data_out), 32'h0000CCEE);
            if (i % 2 == 1) chk($sformatf("l2_lane_valid%0d", i), 32'(d2_lane_valid), 32'h3);
        end
        d2_valid_in = 1'b0;

        idle(3);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/phy_rx_demux_lanes.md
# phy_rx_demux_lanes

Parametrised 1-to-N byte-lane demultiplexer for the PHY receive path. Accepts a serial stream of WIDTH-bit words on the fast clock, distributes them round-robin into LANES lane slots, and presents each completed lane group as one parallel word with a valid/ready handshake. It generalises the fixed 1:2 and 1:4 receive demuxes to any power-of-two lane count, adds back-pressure on both sides and optional flushing of partial groups.

## Interface
- WIDTH, 8, bits per lane word
- LANES, 4, lane count; power of two, 2..16
- IDLE_CYCLES, 4, idle input cycles before a partial-group flush; 1..255; used only with DEMUX_FLUSH_EN
- clk_4f  input  1  fast receive clock; all state on rising edge
- reset  input  1  asynchronous, active-high reset
- data_in  input  WIDTH  serial input word
- valid_in  input  1  data_in valid
- ready_in  output  1  block can accept data_in this cycle
- data_out  output  LANES*WIDTH  lane group; lane k at bits [k*WIDTH +: WIDTH]; lane 0 = first word received
- valid_out  output  1  data_out holds a group
- ready_out  input  1  downstream consumes group this cycle
- lane_valid  output  LANES  per-lane fill mask of data_out
- lane_ptr  output  clog2(LANES)  next lane to be written

## Operation
- Input transfer: valid_in && ready_in at a rising edge.
- Each transfer writes data_in into assembly slot lane_ptr, sets its fill bit, increments lane_ptr modulo LANES.
- Completing transfer (lane_ptr == LANES-1): assembly slots 0..LANES-2 plus data_in load into data_out on the same edge; valid_out <= 1; lane_valid <= all ones; lane_ptr <= 0; fill mask cleared.
- Output slot is free when valid_out == 0, or when valid_out && ready_out in the same cycle.
- ready_in = (lane_ptr != LANES-1) || slot free. Combinational path from ready_out to ready_in is allowed and required.
- Output transfer (valid_out && ready_out) with no simultaneous load: valid_out <= 0, lane_valid <= 0; data_out holds its last value.
- Simultaneous drain and load: new group replaces old with no bubble; valid_out stays 1.
- valid_in low: no state change other than the idle counter.
- data_out, lane_valid stable while valid_out && !ready_out.
- Reset at any time, including mid-group, discards the assembly and the held group.

## Timing
- Reset values: data_out = 0, valid_out = 0, lane_valid = 0, lane_ptr = 0, assembly = 0, idle counter = 0; ready_in = 1 after reset.
- Latency: completing word accepted at edge k -> valid_out = 1 immediately after edge k.
- Sustained throughput: one input word per cycle while ready_out stays high.
- Stall: ready_out low with a group held -> exactly LANES-1 further words accepted, then ready_in = 0 until the group drains.

## Configuration
- DEMUX_FLUSH_EN defined: idle counter increments each cycle with valid_in == 0 and lane_ptr != 0, and clears on any input transfer. On reaching IDLE_CYCLES with the output slot free, the partial group loads into data_out: filled lanes carry data, unfilled lanes are 0, and lane_valid = fill mask. lane_ptr and the counter clear. If the slot is not free, the flush waits and ready_in stays unaffected; a new input transfer before the flush cancels it.
- DEMUX_FLUSH_EN undefined: no idle counter; partial groups wait indefinitely; lane_valid is all ones whenever valid_out = 1.

## Test plan
- WIDTH=8, LANES=4, ready_out=1, stream DD,EE,CC,BB back-to-back -> one cycle after BB accepted, valid_out=1, data_out=32'hBBCCEEDD, lane_valid=4'hF; next group 99,AA,88,77 yields 32'h7788AA99 with no bubble.
- Same stream with valid_in gaps (valid low between EE and CC for 3 cycles, flush off) -> identical data_out; lane_ptr holds at 2 during the gap.
- ready_out=0 after the first group -> 99,AA,88 accepted, ready_in=0 with lane_ptr=3; raising ready_out accepts 77 on the same edge as the drain.
- Assert reset after DD,EE -> all outputs 0, lane_ptr=0; following CC,BB,99,AA gives 32'hAA99BBCC.
- DEMUX_FLUSH_EN, IDLE_CYCLES=4: send 11,22 then idle -> after the 4th idle cycle, data_out=32'h00002211, lane_valid=4'b0011, lane_ptr=0.
- LANES=2: stream FF,DD,EE,CC -> groups 16'hDDFF then 16'hCCEE, lane_ptr toggles 0/1.
